// File: rtl/pl_mem_stage.sv
`timescale 1ns/1ps
// pl_mem_stage: memory-access stage of the RV32 5-stage pipeline.
// Drives a req/ready data bus from the M-stage controls, extends load data,
// holds the MEM/WB register, stalls upstream while the bus is busy and
// reports misaligned accesses and bus timeouts as one-cycle pulses.
module pl_mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPLus4M,
    input  logic [2:0]  funct3M,
    input  logic [31:0] lAuiPCM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPLus4W,
    output logic [31:0] lAuiPCW,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  off;
    logic        is_load;
    logic        access;
    logic        misaligned;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        done_ok;
    logic        timeout;
    logic        mis_now;

    assign off        = ALUResultM[1:0];
    assign is_load    = (ResultSrcM == 2'b01);
    assign access     = MemWriteM | is_load;
    assign misaligned = ((funct3M[1:0] == 2'b01) && off[0]) ||
                        ((funct3M[1:0] == 2'b10) && (off != 2'b00));

    assign mem_we   = MemWriteM;
    assign mem_addr = {ALUResultM[31:2], 2'b00};

    // Byte lanes and lane-replicated store data from the access width
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << off;
                mem_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                mem_be    = 4'b0011 << off;
                mem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = WriteDataM;
            end
        endcase
    end

    // Extract the addressed byte/half from the read word and extend it
    always_comb begin
        shifted   = mem_rdata >> {off, 3'b000};
        load_data = mem_rdata;
        case (funct3M)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Bus request, stall and completion decode from FSM state and M inputs
    always_comb begin
        mem_req = 1'b0;
        StallM  = 1'b0;
        done_ok = 1'b0;
        timeout = 1'b0;
        mis_now = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        mis_now = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_ready) done_ok = 1'b1;
                        else           StallM  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready)                    done_ok = 1'b1;
                else if (cnt >= CNT_W'(TIMEOUT))  timeout = 1'b1;
                else                              StallM  = 1'b1;
            end
            default: ;
        endcase
    end

    // Access FSM and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (StallM) begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (StallM) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: capture on progress, bubble while stalled
    always_ff @(posedge clk) begin
        if (reset || StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPLus4W   <= '0;
            lAuiPCW    <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~mis_now & ~timeout;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load && done_ok) ? load_data : '0;
            RdW        <= RdM;
            PCPLus4W   <= PCPLus4M;
            lAuiPCW    <= lAuiPCM;
            misalign   <= mis_now;
            bus_err    <= timeout;
        end
    end

endmodule

// File: tb/tb_pl_mem_stage.sv
`timescale 1ns/1ps
// Self-checking bench for pl_mem_stage: behavioural model plus directed
// vectors with hand-computed expectations.
module tb_pl_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPLus4M;
    logic [2:0]  funct3M;
    logic [31:0] lAuiPCM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPLus4W;
    logic [31:0] lAuiPCW;
    logic        misalign;
    logic        bus_err;

    pl_mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPLus4M(PCPLus4M), .funct3M(funct3M), .lAuiPCM(lAuiPCM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .PCPLus4W(PCPLus4W), .lAuiPCW(lAuiPCW),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int unsigned nbytes_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00)      return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else                       return 4;
    endfunction

    function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [1:0] o);
        int unsigned n;
        n = nbytes_of(f3);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << o);
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
        int unsigned n;
        logic [31:0] r;
        n = nbytes_of(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
        int unsigned n;
        bit sgn;
        logic [31:0] v, mask;
        case (f3)
            3'b000:  begin n = 1; sgn = 1'b1; end
            3'b100:  begin n = 1; sgn = 1'b0; end
            3'b001:  begin n = 2; sgn = 1'b1; end
            3'b101:  begin n = 2; sgn = 1'b0; end
            default: begin n = 4; sgn = 1'b0; end
        endcase
        if (n == 4) return w;
        v    = w >> (8 * o);
        mask = (32'd1 << (8 * n)) - 32'd1;
        v    = v & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit is_access();
        return MemWriteM || (ResultSrcM == 2'b01);
    endfunction

    function automatic bit is_misaligned();
        return ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
               ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    endfunction

    // cycles the current access has already spent outstanding (0 = none)
    int unsigned m_wait = 0;
    int          cyc    = 0;
    logic        e_rw, e_mis, e_berr;
    logic [1:0]  e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_rdata, e_pc, e_lui;

    function automatic bit model_req();
        return (m_wait > 0) || (is_access() && !is_misaligned());
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_wait = 0;
                {e_rw, e_mis, e_berr, e_rs, e_rd} = '0;
                {e_alu, e_rdata, e_pc, e_lui} = '0;
            end else if (model_req() && !mem_ready && m_wait < TIMEOUT) begin
                m_wait++;
                {e_rw, e_mis, e_berr, e_rs, e_rd} = '0;
                {e_alu, e_rdata, e_pc, e_lui} = '0;
            end else begin
                bit req, ok, timed, mis;
                req   = model_req();
                ok    = req && mem_ready;
                timed = req && !mem_ready;
                mis   = (m_wait == 0) && is_access() && is_misaligned();
                e_rw    = RegWriteM && !mis && !timed;
                e_rs    = ResultSrcM;
                e_alu   = ALUResultM;
                e_rd    = RdM;
                e_pc    = PCPLus4M;
                e_lui   = lAuiPCM;
                e_rdata = (ok && ResultSrcM == 2'b01)
                          ? load_value(funct3M, ALUResultM[1:0], mem_rdata) : 32'd0;
                e_mis   = mis;
                e_berr  = timed;
                m_wait  = 0;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                bit req, stall;
                req   = model_req();
                stall = req && !mem_ready && (m_wait < TIMEOUT);
                chk("mem_req", 32'(mem_req), 32'(req));
                chk("StallM", 32'(StallM), 32'(stall));
                if (req) begin
                    chk("mem_we", 32'(mem_we), 32'(MemWriteM));
                    chk("mem_addr", mem_addr, ALUResultM & ~32'h3);
                    chk("mem_be", 32'(mem_be), 32'(lanes(funct3M, ALUResultM[1:0])));
                    chk("mem_wdata", mem_wdata, replicate(funct3M, WriteDataM));
                end
                chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
                chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
                chk("ALUResultW", ALUResultW, e_alu);
                chk("ReadDataW", ReadDataW, e_rdata);
                chk("RdW", 32'(RdW), 32'(e_rd));
                chk("PCPLus4W", PCPLus4W, e_pc);
                chk("lAuiPCW", lAuiPCW, e_lui);
                chk("misalign", 32'(misalign), 32'(e_mis));
                chk("bus_err", 32'(bus_err), 32'(e_berr));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [2:0] f3);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        ALUResultM = alu;
        WriteDataM = wd;
        RdM        = rd;
        funct3M    = f3;
        PCPLus4M   = 32'h0000_1000 + {25'd0, rd, 2'b00};
        lAuiPCM    = alu ^ 32'hA5A5_0000;
    endtask

    task automatic nop();
        set_m(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 3'b000);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rword;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } zw_t;

    zw_t zw_tab [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        zw_tab[0] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80};
        zw_tab[1] = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        zw_tab[2] = '{1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001};
        zw_tab[3] = '{1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h00AB_0000, 4'b0100, 32'h0, 32'h0000_00AB};
        zw_tab[4] = '{1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        zw_tab[5] = '{1'b0, 3'b011, 32'h0000_010C, 32'h0, 32'h8765_4321, 4'b1111, 32'h0, 32'h8765_4321};
        zw_tab[6] = '{1'b0, 3'b101, 32'h0000_010A, 32'h0, 32'hF00D_0000, 4'b1100, 32'h0, 32'h0000_F00D};

        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        nop();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mid();
        chk("reset_RegWriteW", 32'(RegWriteW), 32'd0);
        chk("reset_ReadDataW", ReadDataW, 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);

        // zero-wait accesses
        foreach (zw_tab[i]) begin
            next_cyc();
            if (zw_tab[i].we) set_m(1'b0, 2'b00, 1'b1, zw_tab[i].addr, zw_tab[i].wd, 5'd4, zw_tab[i].f3);
            else              set_m(1'b1, 2'b01, 1'b0, zw_tab[i].addr, zw_tab[i].wd, 5'd5, zw_tab[i].f3);
            mem_ready = 1'b1;
            mem_rdata = zw_tab[i].rword;
            mid();
            chk("zw_stall", 32'(StallM), 32'd0);
            chk("zw_be", 32'(mem_be), 32'(zw_tab[i].be));
            chk("zw_wdata", mem_wdata, zw_tab[i].wdata);
            next_cyc();
            nop();
            mem_ready = 1'b0;
            mid();
            chk("zw_ReadDataW", ReadDataW, zw_tab[i].ldata);
            chk("zw_RegWriteW", 32'(RegWriteW), 32'(!zw_tab[i].we));
        end

        // SH at 0x202, ready on the fourth cycle
        next_cyc();
        set_m(1'b0, 2'b00, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 3'b001);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("sh_be", 32'(mem_be), 32'h0000_000C);
            chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
            chk("sh_addr", mem_addr, 32'h0000_0200);
            chk("sh_stall", 32'(StallM), 32'd1);
            if (i > 0) chk("sh_bubble", 32'(RegWriteW), 32'd0);
            next_cyc();
        end
        mem_ready = 1'b1;
        mid();
        chk("sh_release", 32'(StallM), 32'd0);
        next_cyc();
        nop();
        mem_ready = 1'b0;
        mid();
        chk("sh_done_alu", ALUResultW, 32'h0000_0202);
        chk("sh_done_req", 32'(mem_req), 32'd0);

        // LW at 0x104 with two wait cycles
        next_cyc();
        set_m(1'b1, 2'b01, 1'b0, 32'h0000_0104, 32'h0, 5'd6, 3'b010);
        repeat (2) begin
            mid();
            chk("lw_stall", 32'(StallM), 32'd1);
            next_cyc();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        next_cyc();
        nop();
        mem_ready = 1'b0;
        mid();
        chk("lw_ReadDataW", ReadDataW, 32'h1234_5678);
        chk("lw_RegWriteW", 32'(RegWriteW), 32'd1);
        chk("lw_no_req", 32'(mem_req), 32'd0);

        // LHU at 0x101 is misaligned
        next_cyc();
        set_m(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 3'b101);
        mid();
        chk("lhu_req", 32'(mem_req), 32'd0);
        chk("lhu_stall", 32'(StallM), 32'd0);
        next_cyc();
        nop();
        mid();
        chk("lhu_misalign", 32'(misalign), 32'd1);
        chk("lhu_RegWriteW", 32'(RegWriteW), 32'd0);
        next_cyc();
        mid();
        chk("lhu_pulse_end", 32'(misalign), 32'd0);

        // LW that never gets ready: timeout
        next_cyc();
        set_m(1'b1, 2'b01, 1'b0, 32'h0000_0110, 32'h0, 5'd9, 3'b010);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (!StallM) break;
            n++;
            next_cyc();
        end
        chk("to_stall_cycles", 32'(n), 32'(TIMEOUT));
        next_cyc();
        set_m(1'b1, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 5'd7, 3'b000);
        mem_ready = 1'b1;   // stray ready with no access must be ignored
        mid();
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_RegWriteW", 32'(RegWriteW), 32'd0);
        next_cyc();
        nop();
        mem_ready = 1'b0;
        mid();
        chk("to_err_end", 32'(bus_err), 32'd0);
        chk("add_RegWriteW", 32'(RegWriteW), 32'd1);
        chk("add_RdW", 32'(RdW), 32'd7);
        chk("add_ALUResultW", ALUResultW, 32'h0000_0055);
        chk("add_ReadDataW", ReadDataW, 32'd0);

        // reset in the second WAIT cycle, with a ready in the same cycle
        next_cyc();
        set_m(1'b1, 2'b01, 1'b0, 32'h0000_0108, 32'h0, 5'd3, 3'b010);
        mid();
        next_cyc();
        mid();
        next_cyc();
        reset = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        mid();
        next_cyc();
        reset = 1'b0;
        mem_ready = 1'b0;
        nop();
        mid();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        chk("rst_RdW", 32'(RdW), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_PCPLus4W", PCPLus4W, 32'd0);
        next_cyc();
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
